time_set_controller: RTL and testbench
======================================

# time_set_controller

Sequencing controller for the clock's time-setting path. It sits between the button debouncers and the BCD timekeeping counter. It runs a RUN/EDIT state machine, holds a shadow copy of HH:MM:SS while the user edits, and steps the selected field with BCD wrap. On commit it issues a one-cycle load to the timekeeper, and it abandons the edit on inactivity.

## Interface
- `TIMEOUT_S`, default 10: number of 1 Hz ticks with no accepted button before EDIT is abandoned; legal range 1–255.
- `i_clk` in 1: system clock, 12 MHz.
- `i_reset` in 1: synchronous, active-high reset.
- `i_tick_1hz` in 1: one-cycle strobe, once per second, from the timekeeper prescaler.
- `i_wr_pulse` in 1: debounced one-cycle pulse; enters EDIT or commits.
- `i_sel_inc_pulse` in 1: debounced pulse; selects the next field.
- `i_sel_dec_pulse` in 1: debounced pulse; selects the previous field.
- `i_val_inc_pulse` in 1: debounced pulse; increments the selected field.
- `i_val_dec_pulse` in 1: debounced pulse; decrements the selected field.
- `i_hh` in 8: live hours, BCD 00–23.
- `i_mm` in 8: live minutes, BCD 00–59.
- `i_ss` in 8: live seconds, BCD 00–59.
- `o_edit` out 1: high while in EDIT.
- `o_sel` out 2: selected field; 2'd0 = HH, 1 = MM, 2 = SS; 3 is never driven.
- `o_blink` out 1: blink phase for the selected field; toggles on each `i_tick_1hz` in EDIT.
- `o_load` out 1: one-cycle strobe to the timekeeper.
- `o_load_hh` out 8: BCD hours to load, valid while `o_load` is high.
- `o_load_mm` out 8: BCD minutes to load, valid while `o_load` is high.
- `o_load_ss` out 8: BCD seconds to load, valid while `o_load` is high.
- `o_disp_hh` out 8: display mux; shadow hours in EDIT, `i_hh` in RUN.
- `o_disp_mm` out 8: display mux; shadow minutes in EDIT, `i_mm` in RUN.
- `o_disp_ss` out 8: display mux; shadow seconds in EDIT, `i_ss` in RUN.

## Operation
- **States**
  - RUN: display follows the live inputs.
  - EDIT: display shows the shadow registers.
- **RUN → EDIT** on `i_wr_pulse`:
  - capture `i_hh`/`i_mm`/`i_ss` into the shadow registers;
  - `o_sel` = 0 (HH);
  - `o_blink` = 1;
  - timeout counter = 0.
- **In RUN**, `sel_*` and `val_*` pulses are ignored.
- **EDIT → RUN** on `i_wr_pulse` (commit):
  - `o_load` = 1 for exactly one cycle;
  - `o_load_*` carry the shadow values;
  - `o_edit` drops in the same cycle `o_load` rises.
- **EDIT → RUN, abandon:** when the timeout counter reaches `TIMEOUT_S`. No load is issued.
- **Priority:** at most one pulse is acted on per cycle, in the order wr > sel_inc > sel_dec > val_inc > val_dec. Lower-priority pulses in the same cycle are dropped.
- **Field select:** `sel_inc` steps 0→1→2→0; `sel_dec` steps 0→2→1→0.
- **Value step:** operates on the selected shadow field in BCD.
  - HH: inc 23→00 and 09→10; dec 00→23 and 10→09.
  - MM/SS: inc 59→00 and x9→(x+1)0; dec 00→59 and x0→(x−1)9.
  - Wrap does not carry into the neighbouring field.
- **Timeout counter:**
  - 8-bit;
  - cleared on any accepted pulse;
  - incremented on `i_tick_1hz` while in EDIT;
  - an accepted pulse in the same cycle as a tick takes precedence (counter cleared).
- **Blink:** `o_blink` toggles on each `i_tick_1hz` in EDIT. It is forced to 0 in RUN.
- **Seconds:** the live seconds keep counting in the timekeeper during EDIT. The shadow SS field is frozen until edited or committed.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- **Reset values:**
  - state = RUN;
  - `o_edit` = 0, `o_sel` = 0, `o_blink` = 0, `o_load` = 0;
  - `o_load_*` = 8'h00;
  - `o_disp_*` = 8'h00 for the reset cycle, then they follow the live inputs.
- **Latency:**
  - a pulse sampled at edge N produces its updated `o_edit`/`o_sel`/`o_disp_*`/`o_load` after edge N, i.e. visible in cycle N+1;
  - the RUN display mux lags the live inputs by 1 cycle.
- **Commit:** exactly 1 cycle of `o_load`. The timekeeper must sample `o_load_*` in that cycle.
- **Back-to-back pulses:** pulses in consecutive cycles are each accepted.
- **Reset:** reset at any point, including mid-EDIT or in the `o_load` cycle, returns to RUN next cycle.
  - If reset coincides with the cycle that would raise `o_load`, no load is issued.
  - An `o_load` already high when reset arrives is deasserted next cycle and never extends.
- **Timeout boundary:** with `TIMEOUT_S` = 10, abandon occurs on the cycle after the 10th tick following the last accepted pulse.

## Test plan
- **Reset then RUN passthrough:** `i_hh/mm/ss` = 12/34/56 → `o_disp_*` = 12/34/56 one cycle later; `o_edit` = 0, `o_load` = 0.
- **Enter EDIT and step hours:** live 23:59:58; wr, then val_inc → `o_disp_hh` = 00; then val_dec twice → 22. `o_disp_mm`/`o_disp_ss` stay 59/58 while the live seconds advance.
- **Minutes BCD wrap and commit:** wr; sel_inc → `o_sel` = 1; from MM = 09, val_inc → 10; from MM = 59, val_inc → 00; from MM = 00, val_dec → 59. Then wr → one-cycle `o_load` with shadow values, `o_edit` = 0.
- **Select wrap and priority:** sel_dec from 0 → 2. Simultaneous sel_inc + val_inc → only `o_sel` changes. Simultaneous wr + val_inc in EDIT → commit, value unchanged.
- **Timeout:** `TIMEOUT_S` = 3; wr, then 3 ticks with no pulses → `o_edit` = 0, no `o_load`. A val_inc after the 2nd tick delays the exit to 3 ticks after that pulse. `o_blink` toggles on every tick.
- **Reset mid-EDIT:** wr, val_inc, then reset asserted in the same cycle as a wr pulse → RUN, `o_load` never asserted, `o_sel` = 0.

Source files
------------

// File: rtl/time_set_controller.sv
// Time-setting sequencer: RUN/EDIT state machine with a BCD shadow copy of HH:MM:SS,
// field select, value stepping, one-cycle commit load and inactivity abandon.
module time_set_controller #(
    parameter int unsigned TIMEOUT_S = 10
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tick_1hz,
    input  logic       i_wr_pulse,
    input  logic       i_sel_inc_pulse,
    input  logic       i_sel_dec_pulse,
    input  logic       i_val_inc_pulse,
    input  logic       i_val_dec_pulse,
    input  logic [7:0] i_hh,
    input  logic [7:0] i_mm,
    input  logic [7:0] i_ss,
    output logic       o_edit,
    output logic [1:0] o_sel,
    output logic       o_blink,
    output logic       o_load,
    output logic [7:0] o_load_hh,
    output logic [7:0] o_load_mm,
    output logic [7:0] o_load_ss,
    output logic [7:0] o_disp_hh,
    output logic [7:0] o_disp_mm,
    output logic [7:0] o_disp_ss
);

    localparam logic [0:0] StRun  = 1'b0;
    localparam logic [0:0] StEdit = 1'b1;

    // Abandon on the tick that would bring the idle count up to TIMEOUT_S.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_S - 1);

    logic [0:0] state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic       blink_q, blink_d;
    logic       load_q, load_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] sh_hh_q, sh_hh_d, sh_mm_q, sh_mm_d, sh_ss_q, sh_ss_d;
    logic [7:0] ld_hh_q, ld_hh_d, ld_mm_q, ld_mm_d, ld_ss_q, ld_ss_d;
    logic [7:0] dp_hh_q, dp_hh_d, dp_mm_q, dp_mm_d, dp_ss_q, dp_ss_d;
    logic       any_pulse;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        if (v == 8'h00) return max;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign any_pulse = i_wr_pulse | i_sel_inc_pulse | i_sel_dec_pulse |
                       i_val_inc_pulse | i_val_dec_pulse;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        blink_d = blink_q;
        load_d  = 1'b0;
        cnt_d   = cnt_q;
        sh_hh_d = sh_hh_q;
        sh_mm_d = sh_mm_q;
        sh_ss_d = sh_ss_q;
        ld_hh_d = ld_hh_q;
        ld_mm_d = ld_mm_q;
        ld_ss_d = ld_ss_q;

        case (state_q)
            StRun: begin
                if (i_wr_pulse) begin
                    state_d = StEdit;
                    sh_hh_d = i_hh;
                    sh_mm_d = i_mm;
                    sh_ss_d = i_ss;
                    sel_d   = 2'd0;
                    blink_d = 1'b1;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                if (i_tick_1hz) blink_d = ~blink_q;
                if (any_pulse) cnt_d = 8'd0;
                else if (i_tick_1hz) cnt_d = cnt_q + 8'd1;

                if (i_wr_pulse) begin
                    state_d = StRun;
                    load_d  = 1'b1;
                    ld_hh_d = sh_hh_q;
                    ld_mm_d = sh_mm_q;
                    ld_ss_d = sh_ss_q;
                end else if (i_sel_inc_pulse) begin
                    sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
                end else if (i_sel_dec_pulse) begin
                    sel_d = (sel_q == 2'd0) ? 2'd2 : sel_q - 2'd1;
                end else if (i_val_inc_pulse) begin
                    case (sel_q)
                        2'd0:    sh_hh_d = bcd_inc(sh_hh_q, 8'h23);
                        2'd1:    sh_mm_d = bcd_inc(sh_mm_q, 8'h59);
                        default: sh_ss_d = bcd_inc(sh_ss_q, 8'h59);
                    endcase
                end else if (i_val_dec_pulse) begin
                    case (sel_q)
                        2'd0:    sh_hh_d = bcd_dec(sh_hh_q, 8'h23);
                        2'd1:    sh_mm_d = bcd_dec(sh_mm_q, 8'h59);
                        default: sh_ss_d = bcd_dec(sh_ss_q, 8'h59);
                    endcase
                end else if (i_tick_1hz && cnt_q == TimeoutLast) begin
                    state_d = StRun;
                end
            end
        endcase

        if (state_d == StRun) begin
            blink_d = 1'b0;
            sel_d   = 2'd0;
            cnt_d   = 8'd0;
        end

        // Display is registered from next-state so it tracks edits with one cycle latency.
        if (state_d == StEdit) begin
            dp_hh_d = sh_hh_d;
            dp_mm_d = sh_mm_d;
            dp_ss_d = sh_ss_d;
        end else begin
            dp_hh_d = i_hh;
            dp_mm_d = i_mm;
            dp_ss_d = i_ss;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StRun;
            sel_q   <= 2'd0;
            blink_q <= 1'b0;
            load_q  <= 1'b0;
            cnt_q   <= 8'd0;
            sh_hh_q <= 8'h00;
            sh_mm_q <= 8'h00;
            sh_ss_q <= 8'h00;
            ld_hh_q <= 8'h00;
            ld_mm_q <= 8'h00;
            ld_ss_q <= 8'h00;
            dp_hh_q <= 8'h00;
            dp_mm_q <= 8'h00;
            dp_ss_q <= 8'h00;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            blink_q <= blink_d;
            load_q  <= load_d;
            cnt_q   <= cnt_d;
            sh_hh_q <= sh_hh_d;
            sh_mm_q <= sh_mm_d;
            sh_ss_q <= sh_ss_d;
            ld_hh_q <= ld_hh_d;
            ld_mm_q <= ld_mm_d;
            ld_ss_q <= ld_ss_d;
            dp_hh_q <= dp_hh_d;
            dp_mm_q <= dp_mm_d;
            dp_ss_q <= dp_ss_d;
        end
    end

    assign o_edit    = (state_q == StEdit);
    assign o_sel     = sel_q;
    assign o_blink   = blink_q;
    assign o_load    = load_q;
    assign o_load_hh = ld_hh_q;
    assign o_load_mm = ld_mm_q;
    assign o_load_ss = ld_ss_q;
    assign o_disp_hh = dp_hh_q;
    assign o_disp_mm = dp_mm_q;
    assign o_disp_ss = dp_ss_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: decimal-arithmetic reference model checked every cycle,
// directed scenarios with literal expectations, then a long randomized run.
module tb_time_set_controller;

    localparam int unsigned TO = 3;

    logic       clk = 1'b0;
    logic       rst, tick, wr, si, sd, vi, vd;
    logic [7:0] hh, mm, ss;
    logic       o_edit, o_blink, o_load;
    logic [1:0] o_sel;
    logic [7:0] o_load_hh, o_load_mm, o_load_ss, o_disp_hh, o_disp_mm, o_disp_ss;

    always #5 clk = ~clk;

    time_set_controller #(.TIMEOUT_S(TO)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_tick_1hz     (tick),
        .i_wr_pulse     (wr),
        .i_sel_inc_pulse(si),
        .i_sel_dec_pulse(sd),
        .i_val_inc_pulse(vi),
        .i_val_dec_pulse(vd),
        .i_hh           (hh),
        .i_mm           (mm),
        .i_ss           (ss),
        .o_edit         (o_edit),
        .o_sel          (o_sel),
        .o_blink        (o_blink),
        .o_load         (o_load),
        .o_load_hh      (o_load_hh),
        .o_load_mm      (o_load_mm),
        .o_load_ss      (o_load_ss),
        .o_disp_hh      (o_disp_hh),
        .o_disp_mm      (o_disp_mm),
        .o_disp_ss      (o_disp_ss)
    );

    // Reference model state, fields kept as plain decimal integers.
    bit m_edit, m_blink, m_load;
    int m_sel, m_cnt;
    int m_sh[3];
    int m_ld[3];
    int m_disp[3];
    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic int fmod(input int f);
        return (f == 0) ? 24 : 60;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_next();
        bit any;
        any = wr | si | sd | vi | vd;
        if (rst) begin
            m_edit = 0; m_blink = 0; m_load = 0; m_sel = 0; m_cnt = 0;
            for (int i = 0; i < 3; i++) begin
                m_sh[i] = 0; m_ld[i] = 0; m_disp[i] = 0;
            end
            return;
        end
        m_load = 0;
        if (!m_edit) begin
            if (wr) begin
                m_edit = 1; m_sel = 0; m_blink = 1; m_cnt = 0;
                m_sh[0] = from_bcd(hh); m_sh[1] = from_bcd(mm); m_sh[2] = from_bcd(ss);
            end
        end else begin
            if (tick) m_blink = !m_blink;
            if (wr) begin
                m_load = 1; m_edit = 0;
                for (int i = 0; i < 3; i++) m_ld[i] = m_sh[i];
            end else if (si) m_sel = (m_sel + 1) % 3;
            else if (sd) m_sel = (m_sel + 2) % 3;
            else if (vi) m_sh[m_sel] = (m_sh[m_sel] + 1) % fmod(m_sel);
            else if (vd) m_sh[m_sel] = (m_sh[m_sel] + fmod(m_sel) - 1) % fmod(m_sel);
            if (any) m_cnt = 0;
            else if (tick) begin
                m_cnt++;
                if (m_cnt == int'(TO)) m_edit = 0;
            end
        end
        if (!m_edit) begin
            m_blink = 0; m_sel = 0; m_cnt = 0;
        end
        if (m_edit) for (int i = 0; i < 3; i++) m_disp[i] = m_sh[i];
        else begin
            m_disp[0] = from_bcd(hh); m_disp[1] = from_bcd(mm); m_disp[2] = from_bcd(ss);
        end
    endtask

    task automatic compare_all();
        chk("edit", o_edit, m_edit);
        chk("sel", o_sel, m_sel);
        chk("blink", o_blink, m_blink);
        chk("load", o_load, m_load);
        chk("disp_hh", o_disp_hh, to_bcd(m_disp[0]));
        chk("disp_mm", o_disp_mm, to_bcd(m_disp[1]));
        chk("disp_ss", o_disp_ss, to_bcd(m_disp[2]));
        if (m_load) begin
            chk("load_hh", o_load_hh, to_bcd(m_ld[0]));
            chk("load_mm", o_load_mm, to_bcd(m_ld[1]));
            chk("load_ss", o_load_ss, to_bcd(m_ld[2]));
        end
    endtask

    // Inputs are set between steps; each step models, clocks once, then compares.
    task automatic step();
        model_next();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst = 0; tick = 0; wr = 0; si = 0; sd = 0; vi = 0; vd = 0;
    endtask

    task automatic set_live(input int h, input int m, input int s);
        hh = to_bcd(h); mm = to_bcd(m); ss = to_bcd(s);
    endtask

    initial begin
        rst = 1; tick = 0; wr = 0; si = 0; sd = 0; vi = 0; vd = 0;
        set_live(7, 8, 9);
        step();
        chk("rst_disp_hh", o_disp_hh, 8'h00);
        chk("rst_load_hh", o_load_hh, 8'h00);
        chk("rst_edit", o_edit, 1'b0);

        set_live(12, 34, 56); step();
        chk("pass_hh", o_disp_hh, 8'h12);
        chk("pass_ss", o_disp_ss, 8'h56);

        // Hours wrap both ways while live seconds advance.
        set_live(23, 59, 58); wr = 1; step();
        chk("enter_edit", o_edit, 1'b1);
        chk("enter_blink", o_blink, 1'b1);
        set_live(23, 59, 59); vi = 1; step();
        chk("hh_inc_wrap", o_disp_hh, 8'h00);
        chk("ss_frozen", o_disp_ss, 8'h58);
        vd = 1; step();
        chk("hh_dec_wrap", o_disp_hh, 8'h23);
        vd = 1; step();
        chk("hh_dec", o_disp_hh, 8'h22);
        wr = 1; step();

        // Minutes wrap and commit.
        set_live(12, 9, 30); wr = 1; step();
        si = 1; step();
        chk("sel_mm", o_sel, 2'd1);
        vi = 1; step();
        chk("mm_09_10", o_disp_mm, 8'h10);
        vd = 1; step(); vd = 1; step(); vd = 1; step(); vd = 1; step();
        vd = 1; step(); vd = 1; step(); vd = 1; step(); vd = 1; step();
        vd = 1; step(); vd = 1; step();
        chk("mm_to_00", o_disp_mm, 8'h00);
        vd = 1; step();
        chk("mm_00_59", o_disp_mm, 8'h59);
        vi = 1; step();
        chk("mm_59_00", o_disp_mm, 8'h00);
        set_live(1, 2, 3); wr = 1; step();
        chk("commit_load", o_load, 1'b1);
        chk("commit_edit", o_edit, 1'b0);
        chk("commit_hh", o_load_hh, 8'h12);
        chk("commit_mm", o_load_mm, 8'h00);
        chk("commit_ss", o_load_ss, 8'h30);
        step();
        chk("load_one_cycle", o_load, 1'b0);

        // Select wrap and priority.
        set_live(5, 6, 7); wr = 1; step();
        sd = 1; step();
        chk("sel_dec_wrap", o_sel, 2'd2);
        si = 1; vi = 1; step();
        chk("prio_sel", o_sel, 2'd0);
        chk("prio_val_kept", o_disp_hh, 8'h05);
        wr = 1; vi = 1; step();
        chk("prio_wr_load", o_load, 1'b1);
        chk("prio_wr_hh", o_load_hh, 8'h05);

        // Timeout with a re-arming pulse after the second tick.
        wr = 1; step();
        tick = 1; step();
        chk("blink_t1", o_blink, 1'b0);
        step(); tick = 1; step();
        chk("blink_t2", o_blink, 1'b1);
        vi = 1; step();
        tick = 1; step(); tick = 1; step();
        chk("to_still_edit", o_edit, 1'b1);
        tick = 1; step();
        chk("to_abandon", o_edit, 1'b0);
        chk("to_no_load", o_load, 1'b0);

        // Reset coinciding with a commit.
        wr = 1; step(); vi = 1; step();
        rst = 1; wr = 1; step();
        chk("rst_no_load", o_load, 1'b0);
        chk("rst_sel", o_sel, 2'd0);
        chk("rst_run", o_edit, 1'b0);

        for (int blk = 0; blk < 24; blk++) begin
            for (int c = 0; c < 200; c++) begin
                int dens;
                dens = (blk % 3 == 0) ? 80 : 5;
                if ($urandom_range(3) == 0) set_live(23, 59, 59);
                else set_live($urandom_range(23), $urandom_range(59), $urandom_range(59));
                tick = ($urandom_range(5) == 0);
                wr = ($urandom_range(dens * 4) == 0);
                si = ($urandom_range(dens) == 0);
                sd = ($urandom_range(dens) == 0);
                vi = ($urandom_range(dens) == 0);
                vd = ($urandom_range(dens) == 0);
                rst = ($urandom_range(299) == 0);
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
